// File: rtl/spi_mcp_rx_pkg.sv
// Shared command-word layout, lane/channel numbering and bus bit positions for the MCP4922 SPI receiver.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
package spi_mcp_rx_pkg;

    // Command word layout
    localparam int WORD_BITS = 16;
    localparam int CMD_AB    = 15;
    localparam int CMD_BUF   = 14;
    localparam int CMD_GA    = 13;
    localparam int CMD_SHDN  = 12;

    // Lanes and channels
    localparam int NUM_LANES = 3;
    localparam int NUM_CH    = 6;
    localparam int LANE_XY   = 0;
    localparam int LANE_RG   = 1;
    localparam int LANE_BI   = 2;

    localparam logic [2:0] CH_X = 3'd0;
    localparam logic [2:0] CH_Y = 3'd1;
    localparam logic [2:0] CH_R = 3'd2;
    localparam logic [2:0] CH_G = 3'd3;
    localparam logic [2:0] CH_B = 3'd4;
    localparam logic [2:0] CH_I = 3'd5;

    // Bit positions in the synchronised bus vector (data lanes share lane numbering)
    localparam int BUS_W    = 6;
    localparam int BUS_SCLK = 3;
    localparam int BUS_CS   = 4;
    localparam int BUS_LAT  = 5;

    // Bit counter: counts to 16, saturates at 17 so long frames stay in error
    localparam int               CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_WORD = 5'd16;
    localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

    // Board wiring: which channel a lane's A/B word lands in
    function automatic logic [2:0] lane_channel(input int lane, input logic ab);
        logic [2:0] ch;
        case (lane)
            LANE_XY: ch = ab ? CH_Y : CH_X;
            LANE_RG: ch = ab ? CH_R : CH_G;
            default: ch = ab ? CH_B : CH_I;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/mcp_lane_rx.sv
// One serial lane: 16-bit MSB-first shift register plus saturating bit counter, decoded at frame close.
// Latency: commit/len_err are combinational on frame_end; shift state updates one clock after each event.
// Backpressure: none; events are single-cycle strobes from the shared edge detector.
module mcp_lane_rx #(
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              bit_shift,
    input  logic              frame_end,
    input  logic              sdat,
    output logic              commit,
    output logic              ab,
    output logic              ga_n,
    output logic              shdn_n,
    output logic [DATA_W-1:0] data,
    output logic              len_err
);
    import spi_mcp_rx_pkg::*;

    logic [WORD_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;

    // Clear on frame open, shift one bit per qualified SCLK rise
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (frame_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (bit_shift) begin
            shift_q <= {shift_q[WORD_BITS-2:0], sdat};
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign commit  = frame_end && (cnt_q == CNT_WORD);
    assign len_err = frame_end && (cnt_q != CNT_WORD);
    assign ab      = shift_q[CMD_AB];
    assign ga_n    = shift_q[CMD_GA];
    assign shdn_n  = shift_q[CMD_SHDN];
    assign data    = shift_q[DATA_W-1:0];

endmodule

// File: rtl/spi_mcp_rx.sv
// Oversampled receiver for the three-lane MCP4922 DAC bus; decodes words into six channels latched on LAT_N.
// Latency: LAT_N pin fall to out_valid/dac_* update is SYNC_STAGES+2 clocks.
// Backpressure: none; clock must be at least 4x SCLK or bits are lost.
module spi_mcp_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_lat_n,
    input  logic              spi_sdat_xy,
    input  logic              spi_sdat_rg,
    input  logic              spi_sdat_bi,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dac_x,
    output logic [DATA_W-1:0] dac_y,
    output logic [DATA_W-1:0] dac_r,
    output logic [DATA_W-1:0] dac_g,
    output logic [DATA_W-1:0] dac_b,
    output logic [DATA_W-1:0] dac_i,
    output logic              out_valid,
    output logic              frame_err,
    output logic [5:0]        shdn_flags,
    output logic [5:0]        gain_flags
);
    import spi_mcp_rx_pkg::*;

    logic [BUS_W-1:0] bus_pin;
    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] bus_s;
    logic [2:0]       hist_q;      // {lat, cs, sclk} one cycle behind bus_s
    logic             armed_q;

    logic sclk_rise, cs_fall, cs_rise, lat_fall;
    logic frame_start, bit_shift, frame_end, lat_evt;

    logic [NUM_LANES-1:0] lane_commit, lane_ab, lane_ga_n, lane_shdn_n, lane_len_err;
    logic [DATA_W-1:0]    lane_data [NUM_LANES];
    logic [2:0]           lane_ch   [NUM_LANES];

    logic [DATA_W-1:0] in_q  [NUM_CH];
    logic [DATA_W-1:0] dac_q [NUM_CH];
    logic [5:0]        shdn_q, gain_q;
    logic              lat_q, out_valid_q, frame_err_q;

    assign bus_pin = {spi_lat_n, spi_cs_n, spi_sclk, spi_sdat_bi, spi_sdat_rg, spi_sdat_xy};
    assign bus_s   = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for every bus pin, plus history for the three control pins;
    // cleared to 0 so no edge is seen until the synced bus has been high first
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= bus_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= bus_s[BUS_LAT:BUS_SCLK];
        end
    end

    // Arm only after CS_N is seen idle, so a frame cut by reset is discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (bus_s[BUS_CS]) begin
            armed_q <= 1'b1;
        end
    end

    assign sclk_rise = bus_s[BUS_SCLK] & ~hist_q[0];
    assign cs_fall   = ~bus_s[BUS_CS]  &  hist_q[1];
    assign cs_rise   =  bus_s[BUS_CS]  & ~hist_q[1];
    assign lat_fall  = ~bus_s[BUS_LAT] &  hist_q[2];

    assign frame_start = armed_q & cs_fall;
    assign bit_shift   = armed_q & sclk_rise & ~bus_s[BUS_CS];
    assign frame_end   = armed_q & cs_rise;
    assign lat_evt     = armed_q & lat_fall;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mcp_lane_rx #(.DATA_W(DATA_W)) u_lane (
            .clock       (clock),
            .reset       (reset),
            .frame_start (frame_start),
            .bit_shift   (bit_shift),
            .frame_end   (frame_end),
            .sdat        (bus_s[l]),
            .commit      (lane_commit[l]),
            .ab          (lane_ab[l]),
            .ga_n        (lane_ga_n[l]),
            .shdn_n      (lane_shdn_n[l]),
            .data        (lane_data[l]),
            .len_err     (lane_len_err[l])
        );
        assign lane_ch[l] = lane_channel(l, lane_ab[l]);
    end

    // Commit decoded words into the input registers and flag bits (lanes never share a channel)
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                in_q[c] <= '0;
            end
            shdn_q <= '0;
            gain_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_commit[l]) begin
                    in_q[lane_ch[l]]   <= lane_data[l];
                    shdn_q[lane_ch[l]] <= ~lane_shdn_n[l];
                    gain_q[lane_ch[l]] <= ~lane_ga_n[l];
                end
            end
        end
    end

    // Latch one cycle after the LAT_N edge so a commit in the same cycle is included
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                dac_q[c] <= '0;
            end
        end else begin
            lat_q       <= lat_evt;
            out_valid_q <= lat_q;
            if (lat_q) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    dac_q[c] <= in_q[c];
                end
            end
        end
    end

    // Sticky length error; a new error beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else if (|lane_len_err) begin
            frame_err_q <= 1'b1;
        end else if (err_clr) begin
            frame_err_q <= 1'b0;
        end
    end

    assign dac_x      = dac_q[CH_X];
    assign dac_y      = dac_q[CH_Y];
    assign dac_r      = dac_q[CH_R];
    assign dac_g      = dac_q[CH_G];
    assign dac_b      = dac_q[CH_B];
    assign dac_i      = dac_q[CH_I];
    assign out_valid  = out_valid_q;
    assign frame_err  = frame_err_q;
    assign shdn_flags = shdn_q;
    assign gain_flags = gain_q;

endmodule

// File: tb/tb_spi_mcp_rx.sv
// Self-checking bench for spi_mcp_rx: bus model at clock/4 SCLK, channel-level reference model.
// Latency: expects each LAT_N fall to produce out_valid exactly SYNC+2 clocks later.
// Backpressure: n/a; stimulus is open-loop and every wait is a fixed cycle count.
module tb_spi_mcp_rx;
    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_lat_n = 1'b1;
    logic        spi_sdat_xy = 1'b0, spi_sdat_rg = 1'b0, spi_sdat_bi = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] dac_x, dac_y, dac_r, dac_g, dac_b, dac_i;
    logic        out_valid, frame_err;
    logic [5:0]  shdn_flags, gain_flags;

    spi_mcp_rx #(.SYNC_STAGES(SYNC), .DATA_W(12)) dut (
        .clock(clock), .reset(reset),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_lat_n(spi_lat_n),
        .spi_sdat_xy(spi_sdat_xy), .spi_sdat_rg(spi_sdat_rg), .spi_sdat_bi(spi_sdat_bi),
        .err_clr(err_clr),
        .dac_x(dac_x), .dac_y(dac_y), .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b), .dac_i(dac_i),
        .out_valid(out_valid), .frame_err(frame_err),
        .shdn_flags(shdn_flags), .gain_flags(gain_flags)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: channel index 0..5 = x,y,r,g,b,i
    logic [11:0] m_in [6];
    logic [5:0]  m_shdn = '0, m_gain = '0;
    logic        m_err = 1'b0;
    logic [71:0] m_dac = '0;
    logic [71:0] q_vals [$];
    int          q_due  [$];

    function automatic int chan_of(input int lane, input logic ab);
        case (lane)
            0:       return ab ? 1 : 0;   // XY: A->x, B->y
            1:       return ab ? 2 : 3;   // RG: A->g, B->r
            default: return ab ? 4 : 5;   // BI: A->i, B->b
        endcase
    endfunction

    function automatic logic [71:0] snap();
        logic [71:0] v;
        for (int c = 0; c < 6; c++) v[c*12 +: 12] = m_in[c];
        return v;
    endfunction

    task automatic model_commit(input logic [15:0] w, input int lane);
        int c;
        c = chan_of(lane, w[15]);
        m_in[c]   = w[11:0];
        m_shdn[c] = ~w[12];
        m_gain[c] = ~w[13];
    endtask

    task automatic model_reset();
        for (int c = 0; c < 6; c++) m_in[c] = '0;
        m_shdn = '0; m_gain = '0; m_err = 1'b0; m_dac = '0;
        q_vals.delete(); q_due.delete();
    endtask

    task automatic push_latch();
        q_vals.push_back(snap());
        q_due.push_back(cyc + SYNC + 2);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name);
        check_val({name, "_err"},  {15'h0, frame_err}, {15'h0, m_err});
        check_val({name, "_shdn"}, {10'h0, shdn_flags}, {10'h0, m_shdn});
        check_val({name, "_gain"}, {10'h0, gain_flags}, {10'h0, m_gain});
    endtask

    // lat_mode: 0 none, 1 LAT_N falls with CS_N rise, 2 LAT_N falls with CS_N fall
    // rst_at: bit index at which reset is pulsed mid-frame (-1 = never)
    // clr_race: pulse err_clr in the cycle the length error is recorded
    task automatic send_frame(input logic [15:0] wxy, input logic [15:0] wrg, input logic [15:0] wbi,
                              input int nbits, input int lat_mode, input int rst_at, input bit clr_race);
        bit aborted = 1'b0;
        spi_cs_n = 1'b0;
        if (lat_mode == 2) begin
            spi_lat_n = 1'b0;
            push_latch();
        end
        wait_cyc(2);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                model_reset();
                aborted = 1'b1;
                wait_cyc(3);
                reset = 1'b0;
            end
            spi_sclk    = 1'b0;
            spi_sdat_xy = (i < 16) ? wxy[15-i] : 1'b0;
            spi_sdat_rg = (i < 16) ? wrg[15-i] : 1'b0;
            spi_sdat_bi = (i < 16) ? wbi[15-i] : 1'b0;
            wait_cyc(2);
            spi_sclk = 1'b1;
            wait_cyc(2);
        end
        spi_sclk = 1'b0;
        if (lat_mode == 2) spi_lat_n = 1'b1;
        wait_cyc(2);
        spi_cs_n = 1'b1;
        if (!aborted) begin
            if (nbits == 16) begin
                model_commit(wxy, 0);
                model_commit(wrg, 1);
                model_commit(wbi, 2);
            end else begin
                m_err = 1'b1;
            end
        end
        if (lat_mode == 1) begin
            spi_lat_n = 1'b0;
            push_latch();
        end
        if (clr_race) begin
            wait_cyc(2);
            err_clr = 1'b1;
            wait_cyc(1);
            err_clr = 1'b0;
        end
        if (lat_mode == 1) begin
            wait_cyc(8);
            spi_lat_n = 1'b1;
        end
        wait_cyc(6);
    endtask

    task automatic pulse_lat();
        spi_lat_n = 1'b0;
        push_latch();
        wait_cyc(8);
        spi_lat_n = 1'b1;
        wait_cyc(6);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        wait_cyc(2);
    endtask

    // Per-cycle compare: out_valid timing/contents and held dac_* values
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (q_due.size() > 0 && cyc > q_due[0]) begin
                vectors++;
                miscompares++;
                $display("FAIL latch_missing: got no out_valid by cycle %0d expected at %0d", cyc, q_due[0]);
                m_dac = q_vals.pop_front();
                void'(q_due.pop_front());
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (q_due.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_valid_spurious: got pulse at cycle %0d expected none", cyc);
                end else begin
                    if (cyc != q_due[0]) begin
                        miscompares++;
                        $display("FAIL out_valid_latency: got cycle %0d expected %0d", cyc, q_due[0]);
                    end
                    m_dac = q_vals.pop_front();
                    void'(q_due.pop_front());
                end
            end
            vectors++;
            if ({dac_i, dac_b, dac_g, dac_r, dac_y, dac_x} !== m_dac) begin
                miscompares++;
                $display("FAIL dac_outputs: got %h expected %h",
                         {dac_i, dac_b, dac_g, dac_r, dac_y, dac_x}, m_dac);
            end
        end
    end

    initial begin
        logic [15:0] wa [3];
        logic [15:0] wb [3];
        for (int c = 0; c < 6; c++) m_in[c] = '0;

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(6);
        check_status("reset");
        check_val("reset_valid", {15'h0, out_valid}, 16'h0);

        // Basic A/B frames then a latch
        send_frame(16'h7123, 16'h7456, 16'h7789, 16, 0, -1, 1'b0);
        send_frame(16'hFABC, 16'hF0F0, 16'hF00F, 16, 0, -1, 1'b0);
        pulse_lat();
        check_val("t1_x", {4'h0, dac_x}, 16'h0123);
        check_val("t1_y", {4'h0, dac_y}, 16'h0ABC);
        check_val("t1_g", {4'h0, dac_g}, 16'h0456);
        check_status("t1");

        // Two commits without a latch: last word wins, outputs hold meanwhile
        send_frame(16'h7111, 16'h7456, 16'h7789, 16, 0, -1, 1'b0);
        send_frame(16'h7222, 16'h7456, 16'h7789, 16, 0, -1, 1'b0);
        check_val("t2_hold", {4'h0, dac_x}, 16'h0123);
        pulse_lat();
        check_val("t2_x", {4'h0, dac_x}, 16'h0222);

        // Short and long frames are errors and commit nothing; clear; set beats clear
        send_frame(16'h7333, 16'h7333, 16'h7333, 15, 0, -1, 1'b0);
        check_val("t3_err", {15'h0, frame_err}, 16'h1);
        check_status("t3");
        pulse_lat();
        check_val("t3_x", {4'h0, dac_x}, 16'h0222);
        clear_err();
        check_val("t3_clr", {15'h0, frame_err}, 16'h0);
        send_frame(16'h7344, 16'h7344, 16'h7344, 18, 0, -1, 1'b0);
        check_status("t3_long");
        clear_err();
        send_frame(16'h7355, 16'h7355, 16'h7355, 15, 0, -1, 1'b1);
        check_val("t3_race", {15'h0, frame_err}, 16'h1);
        clear_err();
        check_status("t3_end");

        // G channel, shutdown asserted, gain 1x: G is flag bit 3 in {i,b,g,r,y,x}
        send_frame(16'h7222, 16'h6800, 16'h7789, 16, 0, -1, 1'b0);
        check_val("t4_shdn_g", {15'h0, shdn_flags[3]}, 16'h1);
        check_val("t4_gain_g", {15'h0, gain_flags[3]}, 16'h0);
        check_status("t4");

        // LAT_N fall together with CS_N rise picks up the new word
        send_frame(16'h7444, 16'h7456, 16'h7789, 16, 1, -1, 1'b0);
        check_val("t_sim_rise", {4'h0, dac_x}, 16'h0444);
        // LAT_N fall together with CS_N fall latches old data; frame still decodes
        send_frame(16'h7555, 16'h7456, 16'h7789, 16, 2, -1, 1'b0);
        check_val("t_sim_fall", {4'h0, dac_x}, 16'h0444);
        pulse_lat();
        check_val("t_sim_fall2", {4'h0, dac_x}, 16'h0555);

        // LAT_N held low: one latch only
        spi_lat_n = 1'b0;
        push_latch();
        wait_cyc(8);
        send_frame(16'h7666, 16'h7456, 16'h7789, 16, 0, -1, 1'b0);
        spi_lat_n = 1'b1;
        wait_cyc(6);
        check_val("t_hold_low", {4'h0, dac_x}, 16'h0555);
        pulse_lat();
        check_val("t_hold_low2", {4'h0, dac_x}, 16'h0666);

        // Reset in the middle of a frame: remainder ignored, no error, next frame fine
        send_frame(16'h7777, 16'h7777, 16'h7777, 16, 0, 8, 1'b0);
        check_status("t5_after_rst");
        check_val("t5_x0", {4'h0, dac_x}, 16'h0000);
        send_frame(16'h7888, 16'h7456, 16'h7789, 16, 0, -1, 1'b0);
        pulse_lat();
        check_val("t5_x", {4'h0, dac_x}, 16'h0888);
        check_val("t5_y_unwritten", {4'h0, dac_y}, 16'h0000);
        check_status("t5");

        // Random updates on all six channels
        for (int n = 0; n < 250; n++) begin
            for (int l = 0; l < 3; l++) begin
                wa[l] = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
                wb[l] = {1'b1, 3'($urandom_range(0, 7)), 12'($urandom)};
            end
            send_frame(wa[0], wa[1], wa[2], 16, 0, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                send_frame(wb[0], wb[1], wb[2], 16, 1, -1, 1'b0);
            end else begin
                send_frame(wb[0], wb[1], wb[2], 16, 0, -1, 1'b0);
                pulse_lat();
            end
            if (n % 50 == 0) check_status("rand");
        end
        check_status("rand_end");

        wait_cyc(10);
        vectors++;
        if (q_due.size() != 0) begin
            miscompares++;
            $display("FAIL latch_drain: got %0d pending latches expected 0", q_due.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
